utx_sched: RTL

Byte scheduler sharing the single UART transmitter `phy_utx` between `N_REQ` requesters. It arbitrates round-robin at packet granularity and hands one byte at a time to the phy as a one-cycle `tx_vld` pulse. The phy has no busy output, so the scheduler enforces a minimum inter-byte gap counted in `pluse_us` ticks. It sits between the command/telemetry sources in `commu_top` and `phy_utx`. `phy_utx` is built without `SEND_55AA_TEST`.

---
 rtl/utx_pkg.sv | 25 ++
 rtl/utx_rr_pick.sv | 35 +++
 rtl/utx_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/utx_pkg.sv
// utx_pkg: shared types and constants for the UART transmit scheduler.
//   utx_st_t           scheduler state encoding (IDLE, ARB, SEND, GAP)
//   UTX_GAP_US_DEF     default inter-byte gap in pluse_us ticks
//   UTX_TIMEOUT_US_DEF default idle limit inside a packet in pluse_us ticks
//   UTX_CNT_W          width of the gap and timeout counters
//   sat_inc            saturating counter increment
package utx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } utx_st_t;

  localparam int UTX_GAP_US_DEF     = 400;
  localparam int UTX_TIMEOUT_US_DEF = 5000;
  localparam int UTX_CNT_W          = 16;

  // Counters hold at all-ones rather than wrapping back to zero.
  function automatic logic [UTX_CNT_W-1:0] sat_inc(input logic [UTX_CNT_W-1:0] v);
    return (v == {UTX_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/utx_rr_pick.sv
// utx_rr_pick: combinational round-robin picker.
//   req  : request vector, one bit per requester
//   ptr  : index of the requester with highest priority
//   pick : one-hot winner, first set bit of req searching upward from ptr
//   any  : at least one request bit is set
module utx_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         pick,
  output logic                     any
);

  localparam int PW = $clog2(N_REQ);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/utx_sched.sv
// utx_sched: shares one phy_utx transmitter between N_REQ byte sources.
// Round-robin arbitration at packet granularity; each accepted byte is
// handed to the phy as a one-cycle tx_vld pulse, and the next byte is held
// off for GAP_US pluse_us ticks because the phy has no busy indication.
//   clk_sys, rst_n : clock, asynchronous active-low reset
//   pluse_us       : one-cycle tick every microsecond
//   req_vld/req_data/req_last/req_rdy : per-requester byte handshake
//   grant          : one-hot current packet owner (0 when none)
//   tx_data/tx_vld : byte and strobe to phy_utx
//   busy           : scheduler not idle
//   timeout        : one-cycle pulse when an owner is dropped for inactivity
module utx_sched
  import utx_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_US     = UTX_GAP_US_DEF,
  parameter int TIMEOUT_US = UTX_TIMEOUT_US_DEF
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               pluse_us,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_rdy,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_vld,
  output logic               busy,
  output logic               timeout
);

  localparam int PW = $clog2(N_REQ);
  // Terminal values are compared before the increment so the action lands
  // on the GAP_US-th / TIMEOUT_US-th tick itself.
  localparam logic [UTX_CNT_W-1:0] GAP_TERM = UTX_CNT_W'(GAP_US - 1);
  localparam logic [UTX_CNT_W-1:0] TO_TERM  = UTX_CNT_W'(TIMEOUT_US - 1);

  utx_st_t              state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        g_idx;
  logic                 last_q;
  logic [UTX_CNT_W-1:0] gap_cnt;
  logic [UTX_CNT_W-1:0] to_cnt;

  logic [N_REQ-1:0]     pick;
  logic                 pick_any;
  logic [7:0]           g_data;
  logic                 g_last;
  logic                 hs;

  utx_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req_vld),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (pick_any)
  );

  function automatic logic [PW-1:0] oh2idx(input logic [N_REQ-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = PW'(i);
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
    return (g == PW'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // Byte and last flag of the current owner.
  always_comb begin
    g_data = 8'h00;
    g_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_idx == PW'(i)) begin
        g_data = req_data[8*i +: 8];
        g_last = req_last[i];
      end
    end
  end

  // req_rdy only ever equals grant in SEND, so this is the owner's handshake.
  assign hs   = |(req_vld & req_rdy);
  assign busy = (state != IDLE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      g_idx   <= '0;
      grant   <= '0;
      req_rdy <= '0;
      tx_data <= 8'h00;
      tx_vld  <= 1'b0;
      timeout <= 1'b0;
      last_q  <= 1'b0;
      gap_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      tx_vld  <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_vld) state <= ARB;
        end
        ARB: begin
          if (pick_any) begin
            grant   <= pick;
            req_rdy <= pick;
            g_idx   <= oh2idx(pick);
            to_cnt  <= '0;
            state   <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          // A handshake takes priority over a timeout on the same tick.
          if (hs) begin
            tx_data <= g_data;
            tx_vld  <= 1'b1;
            last_q  <= g_last;
            gap_cnt <= '0;
            req_rdy <= '0;
            state   <= GAP;
          end else if (pluse_us) begin
            to_cnt <= sat_inc(to_cnt);
            if (to_cnt == TO_TERM) begin
              timeout <= 1'b1;
              grant   <= '0;
              req_rdy <= '0;
              rr_ptr  <= ptr_next(g_idx);
              state   <= IDLE;
            end
          end
        end
        GAP: begin
          if (pluse_us) begin
            gap_cnt <= sat_inc(gap_cnt);
            if (gap_cnt == GAP_TERM) begin
              if (last_q) begin
                grant  <= '0;
                rr_ptr <= ptr_next(g_idx);
                state  <= IDLE;
              end else begin
                to_cnt  <= '0;
                req_rdy <= grant;
                state   <= SEND;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
